// File: rtl/w0rm_charlcd_pkg.sv
// Shared definitions for the character-LCD sequencer.
//  - Register offsets of the LCD peripheral (CTRL/INST/DATA) relative to its base.
//  - CTRL bit positions: EN enables the peripheral, RDY reports "last access finished".
//  - HD44780 4-bit power-on command list and the two line-start commands.
//  - Sequencer state encoding.
package w0rm_charlcd_pkg;

  localparam logic [31:0] OFF_CTRL = 32'h0;
  localparam logic [31:0] OFF_INST = 32'h4;
  localparam logic [31:0] OFF_DATA = 32'h8;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_RDY = 1;

  localparam int         INIT_LEN  = 6;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRON,
    S_EN_WR,
    S_CMD_WR,
    S_POLL,
    S_DELAY,
    S_READY,
    S_ERROR
  } state_t;

  // 0x33,0x32 force 4-bit mode from any prior interface state; then 2 lines/5x8,
  // display on, clear, entry mode increment.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return CMD_CLEAR;
      3'd5:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/w0rm_charlcd_delay.sv
// Loadable down-counter used for all LCD timing waits.
//  clk_i   in  clock
//  rst_i   in  asynchronous active-high reset
//  load_i  in  load strobe; counter takes value_i-1 (a value of 0 behaves as 1)
//  value_i in  delay length in cycles
//  done_o  out counter has reached zero
module w0rm_charlcd_delay (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] value_i,
  output logic        done_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (value_i == 32'd0) ? 32'd0 : value_i - 32'd1;
    end else if (cnt_q != 32'd0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign done_o = (cnt_q == 32'd0);

endmodule

// File: rtl/w0rm_charlcd_sequencer.sv
// Bus master driving a 4-bit HD44780 LCD peripheral: runs the power-on init list
// after start_i, then streams the 2x16 frame buffer on every refresh request.
// Every INST/DATA write is followed by CTRL reads until the ready bit is set.
//  mem_clk / cpu_reset        clock, asynchronous active-high reset
//  start_i                    begin init (from IDLE or ERROR)
//  refresh_i                  request one frame transfer (latched)
//  fb_we_i/fb_addr_i/fb_data_i frame buffer write port (0-15 line 1, 16-31 line 2)
//  busy_o/init_done_o/error_o status
//  m_valid_o/m_read_o/m_write_o/m_addr_o/m_data_o  request port (one-cycle strobe)
//  m_valid_i/m_data_i         peripheral response, m_data_i[1] = ready
module w0rm_charlcd_sequencer
  import w0rm_charlcd_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] LCD_BASE   = 32'h4000_0000,
  parameter logic [31:0]           DLY_PWRON  = 32'd1_500_000,
  parameter logic [31:0]           DLY_CMD    = 32'd4_000,
  parameter logic [31:0]           DLY_CLEAR  = 32'd160_000,
  parameter int unsigned           POLL_LIMIT = 1024,
  parameter int unsigned           ACK_LIMIT  = 15
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  start_i,
  input  logic                  refresh_i,
  input  logic                  fb_we_i,
  input  logic [4:0]            fb_addr_i,
  input  logic [7:0]            fb_data_i,
  output logic                  busy_o,
  output logic                  init_done_o,
  output logic                  error_o,
  output logic                  m_valid_o,
  output logic                  m_read_o,
  output logic                  m_write_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_valid_i,
  input  logic [DATA_WIDTH-1:0] m_data_i
);

  state_t                state_q;
  logic [7:0]            fb_q [32];
  logic                  m_valid_q, m_read_q, m_write_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  init_done_q, error_q, pending_q;
  logic [2:0]            rom_idx_q;     // next init command to send
  logic [4:0]            char_idx_q;    // next frame-buffer index to send
  logic                  frame_q;       // streaming a frame rather than the init list
  logic                  line_pend_q;   // next frame item is a line-start command
  logic                  frame_end_q;   // last character of the frame has been sent
  logic                  clear_q;       // command in flight is the slow clear
  logic [31:0]           ack_cnt_q, poll_cnt_q;
  logic                  dly_load_q, dly_done;
  logic [31:0]           dly_val_q;
  logic                  req_wait;
  logic [7:0]            nxt_byte;
  logic                  nxt_data;
  logic                  unused_rd_bits;

  w0rm_charlcd_delay u_delay (
    .clk_i   (mem_clk),
    .rst_i   (cpu_reset),
    .load_i  (dly_load_q),
    .value_i (dly_val_q),
    .done_o  (dly_done)
  );

  // Only the ready bit of the CTRL read data carries meaning.
  assign unused_rd_bits = ^{m_data_i[DATA_WIDTH-1:CTRL_RDY+1], m_data_i[CTRL_RDY-1:0]};

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int i = 0; i < 32; i++) fb_q[i] <= 8'h20;
    end else if (fb_we_i) begin
      fb_q[fb_addr_i] <= fb_data_i;
    end
  end

  // Next item to write; the frame-buffer read happens on the issuing edge, so a
  // same-cycle CPU write to that index is not seen until the next refresh.
  always_comb begin
    nxt_byte = 8'h00;
    nxt_data = 1'b0;
    if (!frame_q) begin
      nxt_byte = init_cmd(rom_idx_q);
    end else if (line_pend_q) begin
      nxt_byte = char_idx_q[4] ? CMD_LINE2 : CMD_LINE1;
    end else begin
      nxt_byte = fb_q[char_idx_q];
      nxt_data = 1'b1;
    end
  end

  assign req_wait = (state_q inside {S_EN_WR, S_CMD_WR, S_POLL});

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q     <= S_IDLE;
      m_valid_q   <= 1'b0;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      pending_q   <= 1'b0;
      rom_idx_q   <= '0;
      char_idx_q  <= '0;
      frame_q     <= 1'b0;
      line_pend_q <= 1'b0;
      frame_end_q <= 1'b0;
      clear_q     <= 1'b0;
      ack_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      dly_load_q  <= 1'b0;
      dly_val_q   <= '0;
    end else begin
      m_valid_q  <= 1'b0;
      dly_load_q <= 1'b0;
      // Request qualifiers hold until acknowledged; a new issue below overrides.
      if (req_wait && m_valid_i) begin
        m_read_q  <= 1'b0;
        m_write_q <= 1'b0;
        m_addr_q  <= '0;
        m_data_q  <= '0;
      end
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start_i) begin
            state_q     <= S_PWRON;
            error_q     <= 1'b0;
            init_done_q <= 1'b0;
            dly_load_q  <= 1'b1;
            dly_val_q   <= DLY_PWRON;
          end
        end
        S_PWRON: begin
          if (!dly_load_q && dly_done) begin
            state_q   <= S_EN_WR;
            m_valid_q <= 1'b1;
            m_write_q <= 1'b1;
            m_addr_q  <= LCD_BASE + ADDR_WIDTH'(OFF_CTRL);
            m_data_q  <= DATA_WIDTH'(1) << CTRL_EN;
            ack_cnt_q <= '0;
          end
        end
        S_EN_WR: begin
          // Short hop through DELAY so that all command writes share one issue path.
          if (m_valid_i) begin
            state_q    <= S_DELAY;
            frame_q    <= 1'b0;
            rom_idx_q  <= '0;
            dly_load_q <= 1'b1;
            dly_val_q  <= 32'd1;
          end
        end
        S_CMD_WR: begin
          if (m_valid_i) begin
            state_q    <= S_POLL;
            poll_cnt_q <= '0;
            m_valid_q  <= 1'b1;
            m_read_q   <= 1'b1;
            m_addr_q   <= LCD_BASE + ADDR_WIDTH'(OFF_CTRL);
            ack_cnt_q  <= '0;
          end
        end
        S_POLL: begin
          if (m_valid_i) begin
            if (m_data_i[CTRL_RDY]) begin
              state_q    <= S_DELAY;
              dly_load_q <= 1'b1;
              dly_val_q  <= clear_q ? DLY_CLEAR : DLY_CMD;
            end else if (poll_cnt_q == 32'(POLL_LIMIT - 1)) begin
              state_q     <= S_ERROR;
              error_q     <= 1'b1;
              init_done_q <= 1'b0;
            end else begin
              poll_cnt_q <= poll_cnt_q + 32'd1;
              m_valid_q  <= 1'b1;
              m_read_q   <= 1'b1;
              m_addr_q   <= LCD_BASE + ADDR_WIDTH'(OFF_CTRL);
              ack_cnt_q  <= '0;
            end
          end
        end
        S_DELAY: begin
          if (!dly_load_q && dly_done) begin
            if (!frame_q && rom_idx_q == 3'(INIT_LEN)) begin
              state_q     <= S_READY;
              init_done_q <= 1'b1;
            end else if (frame_q && frame_end_q) begin
              state_q <= S_READY;
              frame_q <= 1'b0;
            end else begin
              state_q   <= S_CMD_WR;
              m_valid_q <= 1'b1;
              m_write_q <= 1'b1;
              m_addr_q  <= LCD_BASE + ADDR_WIDTH'(nxt_data ? OFF_DATA : OFF_INST);
              m_data_q  <= DATA_WIDTH'(nxt_byte);
              ack_cnt_q <= '0;
              clear_q   <= !frame_q && (nxt_byte == CMD_CLEAR);
              if (!frame_q) begin
                rom_idx_q <= rom_idx_q + 3'd1;
              end else if (line_pend_q) begin
                line_pend_q <= 1'b0;
              end else if (char_idx_q == 5'd31) begin
                frame_end_q <= 1'b1;
              end else begin
                char_idx_q  <= char_idx_q + 5'd1;
                line_pend_q <= (char_idx_q == 5'd15);
              end
            end
          end
        end
        S_READY: begin
          if (pending_q) begin
            state_q     <= S_DELAY;
            frame_q     <= 1'b1;
            char_idx_q  <= '0;
            line_pend_q <= 1'b1;
            frame_end_q <= 1'b0;
            pending_q   <= 1'b0;
            dly_load_q  <= 1'b1;
            dly_val_q   <= 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (req_wait && !m_valid_i) begin
        if (ack_cnt_q == 32'(ACK_LIMIT - 1)) begin
          state_q     <= S_ERROR;
          error_q     <= 1'b1;
          init_done_q <= 1'b0;
          m_read_q    <= 1'b0;
          m_write_q   <= 1'b0;
          m_addr_q    <= '0;
          m_data_q    <= '0;
        end else begin
          ack_cnt_q <= ack_cnt_q + 32'd1;
        end
      end
      // Placed last: a request arriving while a frame starts re-arms the next frame.
      if (refresh_i) pending_q <= 1'b1;
    end
  end

  assign busy_o      = (state_q != S_IDLE) && (state_q != S_READY);
  assign init_done_o = init_done_q;
  assign error_o     = error_q;
  assign m_valid_o   = m_valid_q;
  assign m_read_o    = m_read_q;
  assign m_write_o   = m_write_q;
  assign m_addr_o    = m_addr_q;
  assign m_data_o    = m_data_q;

endmodule

// File: tb/tb_w0rm_charlcd_sequencer.sv
// Bench for the character-LCD sequencer with a reactive peripheral model that
// answers one cycle after each request and holds CTRL.ready low for a chosen
// number of polls after every INST/DATA write.
module tb_w0rm_charlcd_sequencer;

  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam int          P_PWRON = 10;
  localparam int          P_CMD   = 3;
  localparam int          P_CLEAR = 20;
  localparam int          P_POLL  = 8;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, refresh = 1'b0, fb_we = 1'b0;
  logic [4:0]  fb_addr = '0;
  logic [7:0]  fb_data = '0;
  logic        busy_o, init_done_o, error_o, m_valid_o, m_read_o, m_write_o;
  logic [31:0] m_addr_o, m_data_o;
  logic        pv_i = 1'b0;
  logic [31:0] pd_i = '0;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  w0rm_charlcd_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LCD_BASE(BASE),
    .DLY_PWRON(32'(P_PWRON)), .DLY_CMD(32'(P_CMD)), .DLY_CLEAR(32'(P_CLEAR)),
    .POLL_LIMIT(P_POLL), .ACK_LIMIT(15)
  ) dut (
    .mem_clk(clk), .cpu_reset(rst), .start_i(start), .refresh_i(refresh),
    .fb_we_i(fb_we), .fb_addr_i(fb_addr), .fb_data_i(fb_data),
    .busy_o(busy_o), .init_done_o(init_done_o), .error_o(error_o),
    .m_valid_o(m_valid_o), .m_read_o(m_read_o), .m_write_o(m_write_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_valid_i(pv_i), .m_data_i(pd_i)
  );

  typedef struct {
    bit         is_data;
    logic [7:0] b;
    int         cyc;
  } wr_t;

  wr_t         wlog[$];
  logic [7:0]  fbm [32];
  int          vld_count = 0, proto_bad = 0, low_cfg = 3, polls_since = 0, low_now = 0;
  bit          never_ready = 0, rsp_pend = 0, prev_v = 0;
  logic [31:0] rsp_data = '0;
  int          n_total = 0, n_pass = 0;

  // Peripheral model: sees a request in its strobe cycle, answers in the next one.
  always @(negedge clk) begin
    pv_i     = rsp_pend;
    pd_i     = rsp_pend ? rsp_data : 32'h0;
    rsp_pend = 0;
    if (m_valid_o) begin
      vld_count++;
      if ((m_read_o == m_write_o) || prev_v) proto_bad++;
      rsp_data = 32'h0;
      if (m_write_o) begin
        if (m_addr_o == BASE + 32'h4 || m_addr_o == BASE + 32'h8) begin
          wlog.push_back('{m_addr_o == BASE + 32'h8, m_data_o[7:0], cyc});
          polls_since = 0;
          low_now = (low_cfg < 0) ? int'($urandom_range(0, 3)) : low_cfg;
        end
      end else begin
        rsp_data = $urandom & ~32'h2;
        if (!never_ready && polls_since >= low_now) rsp_data = rsp_data | 32'h2;
        polls_since++;
      end
      rsp_pend = 1;
    end
    prev_v = m_valid_o;
  end

  // Expected frame item k (0..33): line-1 command, 16 chars, line-2 command, 16 chars.
  function automatic logic [8:0] frame_item(input int k);
    if (k == 0) return {1'b0, 8'h80};
    if (k < 17) return {1'b1, fbm[k-1]};
    if (k == 17) return {1'b0, 8'hC0};
    return {1'b1, fbm[k-2]};
  endfunction

  function automatic logic [7:0] init_item(input int k);
    logic [7:0] lst [6];
    lst = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06};
    return lst[k];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh = 1'b1;
    @(negedge clk); refresh = 1'b0;
  endtask

  task automatic fb_write(input int a, input logic [7:0] d);
    @(negedge clk); fb_we = 1'b1; fb_addr = 5'(a); fb_data = d; fbm[a] = d;
    @(negedge clk); fb_we = 1'b0;
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (init_done_o) begin ok = 1; break; end
    end
  endtask

  task automatic wait_error(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (error_o) begin ok = 1; break; end
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (wlog.size() >= n && !busy_o) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3); #1;
    n_total++;
    if ({busy_o, init_done_o, error_o, m_valid_o, m_read_o, m_write_o} !== 6'b0) begin
      $display("FAIL reset_flags got %b want 000000",
               {busy_o, init_done_o, error_o, m_valid_o, m_read_o, m_write_o});
    end else n_pass++;
    n_total++;
    if (m_addr_o !== 32'h0) $display("FAIL reset_addr got %h want 0", m_addr_o);
    else n_pass++;
    n_total++;
    if (m_data_o !== 32'h0) $display("FAIL reset_data got %h want 0", m_data_o);
    else n_pass++;
    for (int i = 0; i < 32; i++) fbm[i] = 8'h20;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_pwron();
    int n;
    wlog.delete();
    low_cfg = 3;
    n = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (m_valid_o) begin n = i; break; end
    end
    n_total++;
    if (n != P_PWRON + 1) $display("FAIL pwron_latency got %0d want %0d", n, P_PWRON + 1);
    else n_pass++;
    n_total++;
    if ({m_write_o, m_read_o} !== 2'b10) $display("FAIL en_kind got %b want 10", {m_write_o, m_read_o});
    else n_pass++;
    n_total++;
    if (m_addr_o !== BASE) $display("FAIL en_addr got %h want %h", m_addr_o, BASE);
    else n_pass++;
    n_total++;
    if (m_data_o !== 32'h1) $display("FAIL en_data got %h want 1", m_data_o);
    else n_pass++;
  endtask

  task automatic test_init();
    bit ok;
    int sz;
    wait_init(3000, ok);
    n_total++;
    if (!ok) $display("FAIL init_timeout got init_done=0 want 1");
    else n_pass++;
    sz = wlog.size();
    n_total++;
    if (sz != 6) $display("FAIL init_count got %0d want 6", sz);
    else n_pass++;
    for (int k = 0; k < 6 && k < sz; k++) begin
      n_total++;
      if ({wlog[k].is_data, wlog[k].b} !== {1'b0, init_item(k)})
        $display("FAIL init_cmd%0d got %b/%h want 0/%h", k, wlog[k].is_data, wlog[k].b, init_item(k));
      else n_pass++;
    end
    if (sz >= 6) begin
      n_total++;
      if (wlog[5].cyc - wlog[4].cyc < P_CLEAR)
        $display("FAIL clear_gap got %0d want >=%0d", wlog[5].cyc - wlog[4].cyc, P_CLEAR);
      else n_pass++;
    end
    n_total++;
    if ({busy_o, error_o} !== 2'b00) $display("FAIL init_idle got %b want 00", {busy_o, error_o});
    else n_pass++;
  endtask

  task automatic test_frame();
    bit ok;
    int sz;
    fb_write(0, 8'h41);
    fb_write(31, 8'h5A);
    wlog.delete();
    low_cfg = -1;
    pulse_refresh();
    wait_writes(34, 3000, ok);
    n_total++;
    if (!ok) $display("FAIL frame_timeout got %0d writes want 34", wlog.size());
    else n_pass++;
    sz = wlog.size();
    n_total++;
    if (sz != 34) $display("FAIL frame_count got %0d want 34", sz);
    else n_pass++;
    for (int k = 0; k < 34 && k < sz; k++) begin
      n_total++;
      if ({wlog[k].is_data, wlog[k].b} !== frame_item(k))
        $display("FAIL frame_item%0d got %b/%h want %b/%h", k, wlog[k].is_data, wlog[k].b,
                 frame_item(k) >> 8, frame_item(k) & 9'hFF);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sz;
    for (int i = 0; i < 32; i++) fb_write(i, 8'($urandom_range(8'h21, 8'h7E)));
    wlog.delete();
    pulse_refresh();
    for (int i = 0; i < 500 && wlog.size() < 5; i++) @(posedge clk);
    pulse_refresh();
    tick(7);
    pulse_refresh();
    wait_writes(68, 6000, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_timeout got %0d writes want 68", wlog.size());
    else n_pass++;
    tick(200); #1;
    sz = wlog.size();
    n_total++;
    if (sz != 68) $display("FAIL b2b_count got %0d want 68", sz);
    else n_pass++;
    for (int k = 0; k < 68 && k < sz; k++) begin
      n_total++;
      if ({wlog[k].is_data, wlog[k].b} !== frame_item(k % 34))
        $display("FAIL b2b_item%0d got %b/%h want %h", k, wlog[k].is_data, wlog[k].b, frame_item(k % 34));
      else n_pass++;
    end
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy_o);
    else n_pass++;
    n_total++;
    if (proto_bad != 0) $display("FAIL protocol got %0d violations want 0", proto_bad);
    else n_pass++;
  endtask

  task automatic test_error();
    bit ok;
    int snap;
    never_ready = 1;
    wlog.delete();
    pulse_refresh();
    wait_error(2000, ok);
    n_total++;
    if (!ok) $display("FAIL err_timeout got error_o=0 want 1");
    else n_pass++;
    n_total++;
    if (polls_since != P_POLL) $display("FAIL err_polls got %0d want %0d", polls_since, P_POLL);
    else n_pass++;
    n_total++;
    if (init_done_o !== 1'b0) $display("FAIL err_init_done got %b want 0", init_done_o);
    else n_pass++;
    snap = vld_count;
    tick(50); #1;
    n_total++;
    if (vld_count != snap || {m_read_o, m_write_o} !== 2'b00)
      $display("FAIL err_quiet got %0d requests rd/wr=%b want 0/00", vld_count - snap, {m_read_o, m_write_o});
    else n_pass++;
    never_ready = 0;
    low_cfg = -1;
    wlog.delete();
    pulse_start();
    wait_init(3000, ok);
    n_total++;
    if (!ok || error_o !== 1'b0) $display("FAIL err_recover got done=%b err=%b want 1/0", init_done_o, error_o);
    else n_pass++;
    n_total++;
    if (wlog.size() != 6 || wlog[0].b !== 8'h33)
      $display("FAIL err_reinit got %0d writes want 6 starting 33", wlog.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int sz;
    seen = 0;
    pulse_refresh();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (m_valid_o) begin seen = 1; break; end
    end
    n_total++;
    if (!seen) $display("FAIL rmid_no_request got m_valid_o=0 want 1");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({busy_o, init_done_o, error_o, m_valid_o, m_read_o, m_write_o} !== 6'b0 ||
        m_addr_o !== 32'h0 || m_data_o !== 32'h0)
      $display("FAIL rmid_outputs got %b %h %h want all 0",
               {busy_o, init_done_o, error_o, m_valid_o, m_read_o, m_write_o}, m_addr_o, m_data_o);
    else n_pass++;
    for (int i = 0; i < 32; i++) fbm[i] = 8'h20;
    @(negedge clk); rst = 1'b0;
    pulse_start();
    wait_init(3000, ok);
    n_total++;
    if (!ok) $display("FAIL rmid_init got init_done=0 want 1");
    else n_pass++;
    wlog.delete();
    pulse_refresh();
    wait_writes(34, 3000, ok);
    sz = wlog.size();
    n_total++;
    if (!ok || sz != 34) $display("FAIL rmid_count got %0d want 34", sz);
    else n_pass++;
    for (int k = 0; k < 34 && k < sz; k++) begin
      n_total++;
      if ({wlog[k].is_data, wlog[k].b} !== frame_item(k))
        $display("FAIL rmid_item%0d got %b/%h want %h", k, wlog[k].is_data, wlog[k].b, frame_item(k));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pwron();
    test_init();
    test_frame();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
